// File: rtl/ahbl_bus_arbiter.sv
// ahbl_bus_arbiter: registered AHB-Lite arbiter for 2..4 masters sharing one slave-side bus.
// Define AHBL_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
`default_nettype none

module ahbl_bus_arbiter #(
  parameter int NUM_MASTERS = 2
) (
  input  logic                      HCLK,
  input  logic                      HRESETN,
  input  logic [NUM_MASTERS-1:0]    M_REQ,
  output logic [NUM_MASTERS-1:0]    M_GNT,
  input  logic [32*NUM_MASTERS-1:0] M_HADDR,
  input  logic [2*NUM_MASTERS-1:0]  M_HTRANS,
  input  logic [NUM_MASTERS-1:0]    M_HWRITE,
  input  logic [3*NUM_MASTERS-1:0]  M_HSIZE,
  input  logic [3*NUM_MASTERS-1:0]  M_HBURST,
  input  logic [4*NUM_MASTERS-1:0]  M_HPROT,
  input  logic [NUM_MASTERS-1:0]    M_HMASTLOCK,
  input  logic [32*NUM_MASTERS-1:0] M_HWDATA,
  output logic [NUM_MASTERS-1:0]    M_HRESP,
  output logic                      M_HREADY,
  output logic [31:0]               M_HRDATA,
  output logic [31:0]               HADDR,
  output logic [1:0]                HTRANS,
  output logic                      HWRITE,
  output logic [2:0]                HSIZE,
  output logic [2:0]                HBURST,
  output logic [3:0]                HPROT,
  output logic                      HMASTLOCK,
  output logic [31:0]               HWDATA,
  input  logic                      HREADY,
  input  logic                      HRESP,
  input  logic [31:0]               HRDATA,
  output logic [1:0]                MASTER_ID
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 4) begin : g_bad_num_masters
    $error("ahbl_bus_arbiter: NUM_MASTERS must be in 2..4");
  end

  logic [1:0] addr_owner;
  logic [1:0] data_owner;
  logic [1:0] winner;
  logic       rearb;

  // Address/control follow the address-phase owner; write data follows the data-phase owner.
  always_comb begin
    HADDR     = M_HADDR[31:0];
    HTRANS    = M_HTRANS[1:0];
    HWRITE    = M_HWRITE[0];
    HSIZE     = M_HSIZE[2:0];
    HBURST    = M_HBURST[2:0];
    HPROT     = M_HPROT[3:0];
    HMASTLOCK = M_HMASTLOCK[0];
    HWDATA    = M_HWDATA[31:0];
    for (int i = 1; i < NUM_MASTERS; i++) begin
      if (addr_owner == 2'(i)) begin
        HADDR     = M_HADDR[32*i +: 32];
        HTRANS    = M_HTRANS[2*i +: 2];
        HWRITE    = M_HWRITE[i];
        HSIZE     = M_HSIZE[3*i +: 3];
        HBURST    = M_HBURST[3*i +: 3];
        HPROT     = M_HPROT[4*i +: 4];
        HMASTLOCK = M_HMASTLOCK[i];
      end
      if (data_owner == 2'(i)) begin
        HWDATA = M_HWDATA[32*i +: 32];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      M_GNT[i]   = (addr_owner == 2'(i));
      M_HRESP[i] = HRESP && (data_owner == 2'(i));
    end
  end

  assign M_HREADY  = HREADY;
  assign M_HRDATA  = HRDATA;
  assign MASTER_ID = data_owner;

  // Handover only once the owner has finished: bus ready, owner idle and unlocked.
  assign rearb = HREADY && (HTRANS == 2'b00) && !HMASTLOCK;

`ifdef AHBL_ARB_RR_EN
  logic [2:0] cand;
  logic       found;

  // Search starts one past the owner; the owner itself is the last candidate.
  always_comb begin
    winner = addr_owner;
    found  = 1'b0;
    cand   = 3'd0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = {1'b0, addr_owner} + 3'(k);
      if (cand >= 3'(NUM_MASTERS)) begin
        cand = cand - 3'(NUM_MASTERS);
      end
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!found && M_REQ[i] && (cand == 3'(i))) begin
          winner = 2'(i);
          found  = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    winner = addr_owner;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (M_REQ[i]) begin
        winner = 2'(i);
      end
    end
  end
`endif

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      addr_owner <= 2'd0;
      data_owner <= 2'd0;
    end else begin
      if (rearb && (|M_REQ)) begin
        addr_owner <= winner;
      end
      if (HREADY) begin
        data_owner <= addr_owner;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahbl_bus_arbiter.sv
// tb_ahbl_bus_arbiter: directed self-checking bench for ahbl_bus_arbiter with three masters.
`default_nettype none

module tb_ahbl_bus_arbiter;

  localparam int N = 3;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

`ifdef AHBL_ARB_RR_EN
  localparam logic [2:0] EXP_WAIT = 3'b100;
  localparam int         OWN_L    = 2;
  localparam logic [2:0] LOCK_REQ = 3'b011;
  localparam logic [2:0] EXP_LOCK = 3'b001;
`else
  localparam logic [2:0] EXP_WAIT = 3'b001;
  localparam int         OWN_L    = 0;
  localparam logic [2:0] LOCK_REQ = 3'b110;
  localparam logic [2:0] EXP_LOCK = 3'b010;
`endif
  localparam logic [2:0] OWN_GNT = 3'(1 << OWN_L);

  logic          hclk = 1'b0;
  logic          hresetn;
  logic [N-1:0]  m_req, m_gnt, m_hwrite, m_hmastlock, m_hresp;
  logic [32*N-1:0] m_haddr, m_hwdata;
  logic [2*N-1:0]  m_htrans;
  logic [3*N-1:0]  m_hsize, m_hburst;
  logic [4*N-1:0]  m_hprot;
  logic          m_hready;
  logic [31:0]   m_hrdata;
  logic [31:0]   haddr, hwdata, hrdata;
  logic [1:0]    htrans, master_id;
  logic          hwrite, hmastlock, hready, hresp;
  logic [2:0]    hsize, hburst;
  logic [3:0]    hprot;

  int errors = 0;
  int checks = 0;

  always #5 hclk = ~hclk;

  ahbl_bus_arbiter #(.NUM_MASTERS(N)) dut (
    .HCLK(hclk), .HRESETN(hresetn),
    .M_REQ(m_req), .M_GNT(m_gnt),
    .M_HADDR(m_haddr), .M_HTRANS(m_htrans), .M_HWRITE(m_hwrite),
    .M_HSIZE(m_hsize), .M_HBURST(m_hburst), .M_HPROT(m_hprot),
    .M_HMASTLOCK(m_hmastlock), .M_HWDATA(m_hwdata),
    .M_HRESP(m_hresp), .M_HREADY(m_hready), .M_HRDATA(m_hrdata),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hmastlock), .HWDATA(hwdata),
    .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata), .MASTER_ID(master_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_m(input int i, input logic [1:0] tr, input logic [31:0] a,
                       input logic w, input logic lk);
    m_htrans[2*i +: 2]  = tr;
    m_haddr[32*i +: 32] = a;
    m_hwrite[i]         = w;
    m_hmastlock[i]      = lk;
  endtask

  logic [2:0] fair_exp [3];
  logic [2:0] prev_gnt;

  initial begin
`ifdef AHBL_ARB_RR_EN
    fair_exp[0] = 3'b010; fair_exp[1] = 3'b100; fair_exp[2] = 3'b001;
`else
    fair_exp[0] = 3'b001; fair_exp[1] = 3'b001; fair_exp[2] = 3'b001;
`endif
    hresetn  = 1'b0;
    m_req    = 3'b111;
    hready   = 1'b1;
    hresp    = 1'b0;
    hrdata   = 32'h5A5A_0000;
    m_hwdata = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    m_hsize  = {3'd2, 3'd1, 3'd0};
    m_hburst = '0;
    m_hprot  = {4'h3, 4'h2, 4'h1};
    m_htrans = '0; m_haddr = '0; m_hwrite = '0; m_hmastlock = '0;
    set_m(0, IDLE, 32'h0000_00A0, 1'b0, 1'b0);
    set_m(1, IDLE, 32'h0000_01A0, 1'b0, 1'b0);
    set_m(2, IDLE, 32'h0000_02A0, 1'b0, 1'b0);

    // Reset with all masters requesting
    repeat (3) tick();
    check("rst_gnt",    32'(m_gnt), 32'h1);
    check("rst_id",     32'(master_id), 32'h0);
    check("rst_hresp",  32'(m_hresp), 32'h0);
    check("rst_haddr",  haddr, 32'h0000_00A0);
    check("rst_hprot",  32'(hprot), 32'h1);
    check("rst_hready", 32'(m_hready), 32'h1);
    check("rst_hrdata", m_hrdata, 32'h5A5A_0000);

    // Master 0 read that ends in a two-cycle ERROR response
    hresetn = 1'b1;
    m_req   = 3'b001;
    set_m(0, NONSEQ, 32'h0000_0200, 1'b0, 1'b0);
    tick();
    check("err_gnt_a", 32'(m_gnt), 32'h1);
    set_m(0, IDLE, 32'h0000_0200, 1'b0, 1'b0);
    hready = 1'b0;
    hresp  = 1'b1;
    m_req  = 3'b010;
    set_m(1, NONSEQ, 32'h0000_1000, 1'b1, 1'b0);
    #1;
    check("err_resp1", 32'(m_hresp), 32'h1);
    check("err_haddr", haddr, 32'h0000_0200);
    tick();
    check("err_gnt_b", 32'(m_gnt), 32'h1);
    hready = 1'b1;
    #1;
    check("err_resp2", 32'(m_hresp), 32'h1);

    // Handover to master 1 on the idle cycle that closes the error
    tick();
    hresp = 1'b0;
    #1;
    check("ho_gnt",    32'(m_gnt), 32'h2);
    check("ho_haddr",  haddr, 32'h0000_1000);
    check("ho_htrans", 32'(htrans), 32'(NONSEQ));
    check("ho_hwrite", 32'(hwrite), 32'h1);
    check("ho_hsize",  32'(hsize), 32'h1);
    check("ho_id0",    32'(master_id), 32'h0);
    check("ho_resp0",  32'(m_hresp), 32'h0);
    m_req = 3'b101;
    tick();
    check("ho_id1",    32'(master_id), 32'h1);
    check("ho_hwdata", hwdata, 32'hBBBB_0001);
    check("ho_gnt2",   32'(m_gnt), 32'h2);

    // Wait states hold both owners
    set_m(1, IDLE, 32'h0000_1000, 1'b1, 1'b0);
    hready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("ws_gnt", 32'(m_gnt), 32'h2);
      check("ws_id",  32'(master_id), 32'h1);
    end
    hready = 1'b1;
    tick();
    check("ws_rearb", 32'(m_gnt), 32'(EXP_WAIT));
    check("ws_id_after", 32'(master_id), 32'h1);

    // Locked INCR4 followed by an idle that keeps the lock
    m_req = LOCK_REQ;
    m_hburst[3*OWN_L +: 3] = 3'b011;
    set_m(OWN_L, NONSEQ, 32'h0000_3000, 1'b0, 1'b1);
    tick();
    check("lk_gnt0",  32'(m_gnt), 32'(OWN_GNT));
    check("lk_haddr", haddr, 32'h0000_3000);
    check("lk_lock",  32'(hmastlock), 32'h1);
    check("lk_burst", 32'(hburst), 32'h3);
    for (int k = 1; k < 4; k++) begin
      set_m(OWN_L, SEQ, 32'h0000_3000 + 32'(4 * k), 1'b0, 1'b1);
      tick();
      check("lk_gnt_seq", 32'(m_gnt), 32'(OWN_GNT));
    end
    set_m(OWN_L, IDLE, 32'h0000_3010, 1'b0, 1'b1);
    tick();
    check("lk_idle_locked", 32'(m_gnt), 32'(OWN_GNT));
    set_m(OWN_L, IDLE, 32'h0000_3010, 1'b0, 1'b0);
    m_hburst = '0;
    tick();
    check("lk_release", 32'(m_gnt), 32'(EXP_LOCK));

    // Fairness: everyone requests, each owner does one SINGLE then IDLE
    m_req    = 3'b111;
    prev_gnt = EXP_LOCK;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) set_m(i, NONSEQ, 32'h0000_4000 + 32'(256 * i), 1'b0, 1'b0);
      tick();
      check("fair_hold", 32'(m_gnt), 32'(prev_gnt));
      for (int i = 0; i < N; i++) set_m(i, IDLE, 32'h0000_4000 + 32'(256 * i), 1'b0, 1'b0);
      tick();
      check("fair_gnt", 32'(m_gnt), 32'(fair_exp[k]));
      prev_gnt = fair_exp[k];
    end

    // Reset in the middle of a stalled transfer
    m_req = 3'b010;
    tick();
    check("mr_gnt", 32'(m_gnt), 32'h2);
    for (int i = 0; i < N; i++) set_m(i, NONSEQ, 32'h0000_4000 + 32'(256 * i), 1'b0, 1'b0);
    tick();
    check("mr_id", 32'(master_id), 32'h1);
    hresetn = 1'b0;
    hready  = 1'b0;
    tick();
    check("mr_rst_gnt",   32'(m_gnt), 32'h1);
    check("mr_rst_id",    32'(master_id), 32'h0);
    check("mr_rst_haddr", haddr, 32'h0000_4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
